// File: rtl/age_matrix_issue_sel_pkg.sv
// Shared configuration for the age-matrix selectors used by the issue queue and
// the load/store queues: default slot count, derived index width and the row
// type of an age matrix sized for that default.
package age_matrix_issue_sel_pkg;

    // Default number of slots in an issue queue.
    localparam int unsigned ISSUE_Q_N = 8;

    // Slot index width for the default issue-queue size.
    localparam int unsigned ISSUE_Q_IDX_W = $clog2(ISSUE_Q_N);

    // One row of the age matrix: bit j set means "this slot is older than slot j".
    typedef logic [ISSUE_Q_N-1:0] age_row_t;

endpackage : age_matrix_issue_sel_pkg

// File: rtl/age_matrix_oldest_pick.sv
// Purely combinational oldest-first pick over an N x N age matrix.
// A candidate wins when no other candidate is marked older than it.
// Ports:
//   cand   - candidate slots (occupied and requesting)
//   older  - age matrix, older[j][i]=1 means slot j entered before slot i
//   grant  - one-hot winner (zero when no candidate)
//   idx    - encoded winner index (zero when no candidate)
//   any    - at least one candidate present
module age_matrix_oldest_pick
    import age_matrix_issue_sel_pkg::*;
#(
    parameter  int unsigned N     = ISSUE_Q_N,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]          cand,
    input  logic [N-1:0][N-1:0]   older,
    output logic [N-1:0]          grant,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    logic [N-1:0] blocked;

    // A slot is blocked if any other candidate is older than it; diagonal ignored.
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (j != i && cand[j] && older[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign grant = cand & ~blocked;

    // One-hot to binary; OR-reduction is exact because grant is one-hot.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign any = |cand;

endmodule : age_matrix_oldest_pick

// File: rtl/age_matrix_issue_sel.sv
// Stateful oldest-first issue selector for issue-queue slots. Tracks slot
// occupancy and relative age internally (N x N age matrix) and offers the
// oldest ready entry on a valid/ready issue port.
// Optional build macro: AGE_MATRIX_ISSUE_SEL_OUT_REG_EN adds a one-entry output
// register on the issue port (one cycle extra latency, outputs hold under
// backpressure, issue takes effect when the register loads).
// Ports:
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   flush_i        - synchronous clear of all slots (and of the output register)
//   ins_valid_i    - insert a new entry into slot ins_idx_i
//   ins_idx_i      - slot receiving the new entry
//   req_i          - per-slot ready-to-issue, qualified by occupancy
//   sel_valid_o    - an entry is offered
//   sel_idx_o      - index of the offered entry
//   sel_ready_i    - consumer accepts the offered entry
//   occ_o          - occupancy mask
//   full_o/empty_o - all / no slots occupied
module age_matrix_issue_sel
    import age_matrix_issue_sel_pkg::*;
#(
    parameter  int unsigned N     = ISSUE_Q_N,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             ins_valid_i,
    input  logic [IDX_W-1:0] ins_idx_i,
    input  logic [N-1:0]     req_i,
    output logic             sel_valid_o,
    output logic [IDX_W-1:0] sel_idx_o,
    input  logic             sel_ready_i,
    output logic [N-1:0]     occ_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [N-1:0]           occ_q;
    logic [N-1:0]           occ_d;
    logic [N-1:0]           occ_pre;
    logic [N-1:0]           cand;
    logic [N-1:0]           grant;
    logic [N-1:0]           clr_mask;
    logic [N-1:0]           ins_mask;
    logic [N-1:0]           ins_ok;
    logic [N-1:0][N-1:0]    older_q;
    logic [N-1:0][N-1:0]    older_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   issue_fire;

    assign cand = occ_q & req_i;

    age_matrix_oldest_pick #(
        .N (N)
    ) u_pick (
        .cand  (cand),
        .older (older_q),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef AGE_MATRIX_ISSUE_SEL_OUT_REG_EN
    logic             out_v_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             load;

    assign sel_valid_o = out_v_q;
    assign sel_idx_o   = out_idx_q;
    assign issue_fire  = out_v_q & sel_ready_i;
    // Register refills when empty or when its current entry is taken.
    assign load        = ~out_v_q | issue_fire;
    // Slot leaves the queue as it moves into the output register.
    assign clr_mask    = load ? grant : '0;

    // Output register holding the offered entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_v_q   <= 1'b0;
            out_idx_q <= '0;
        end else if (flush_i) begin
            out_v_q   <= 1'b0;
        end else if (load) begin
            out_v_q   <= pick_any;
            out_idx_q <= pick_idx;
        end
    end
`else
    assign sel_valid_o = pick_any;
    assign sel_idx_o   = pick_idx;
    assign issue_fire  = pick_any & sel_ready_i;
    assign clr_mask    = issue_fire ? grant : '0;
`endif

    // Occupancy after this cycle's issue, used to decide who is older than a new entry.
    assign occ_pre = occ_q & ~clr_mask;

    // Decode the insert target; out-of-range indices match nothing.
    always_comb begin
        ins_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ins_mask[i] = ins_valid_i & (ins_idx_i == IDX_W'(i));
        end
    end

    // Inserting into a slot that stays occupied is dropped.
    assign ins_ok = ins_mask & ~occ_pre;

    // Next occupancy and age matrix; flush drops insert and issue alike.
    always_comb begin
        occ_d   = occ_pre | ins_ok;
        older_d = older_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (ins_ok[k]) begin
                older_d[k] = '0;
                for (int unsigned j = 0; j < N; j++) begin
                    if (j != k) begin
                        older_d[j][k] = occ_pre[j];
                    end
                end
            end
        end
        if (flush_i) begin
            occ_d   = '0;
            older_d = older_q;
        end
    end

    // State registers; diagonal bits stay zero and reduce to constants.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q   <= '0;
            older_q <= '0;
        end else begin
            occ_q   <= occ_d;
            older_q <= older_d;
        end
    end

    assign occ_o   = occ_q;
    assign full_o  = &occ_q;
    assign empty_o = ~|occ_q;

`ifndef SYNTHESIS
    // Inserting over a live entry that is not leaving this cycle is a caller bug.
    ins_clash_a : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !flush_i |-> ~|(ins_mask & occ_pre))
        else $error("age_matrix_issue_sel: insert into occupied slot %0d", ins_idx_i);
`endif

endmodule : age_matrix_issue_sel

// File: tb/tb_age_matrix_issue_sel.sv
// Self-checking bench for age_matrix_issue_sel (N=8, default build).
// Stimulus pushes expected issue indices into a queue; a monitor pops and
// compares on every accepted handshake. Status outputs are checked inline.
module tb_age_matrix_issue_sel;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             ins_valid;
    logic [IDX_W-1:0] ins_idx;
    logic [N-1:0]     req;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_ready;
    logic [N-1:0]     occ;
    logic             full;
    logic             empty;

    int vectors;
    int miscompares;
    int exp_q[$];

    age_matrix_issue_sel #(.N(N)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .ins_valid_i (ins_valid),
        .ins_idx_i   (ins_idx),
        .req_i       (req),
        .sel_valid_o (sel_valid),
        .sel_idx_o   (sel_idx),
        .sel_ready_i (sel_ready),
        .occ_o       (occ),
        .full_o      (full),
        .empty_o     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input int idx);
        ins_valid = 1'b1;
        ins_idx   = IDX_W'(idx);
        tick();
        ins_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted offer must match the next expected index.
    always @(negedge clk) begin
        if (rst_n && sel_valid && sel_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected: got idx %0d, none expected at %0t", sel_idx, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(sel_idx) != e) begin
                    miscompares++;
                    $display("FAIL issue_order: got idx %0d expected %0d at %0t", sel_idx, e, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        ins_valid   = 1'b0;
        ins_idx     = '0;
        req         = '0;
        sel_ready   = 1'b0;

        // Reset values
        #2;
        chk("rst_sel_valid", 32'(sel_valid), 32'd0);
        chk("rst_sel_idx",   32'(sel_idx),   32'd0);
        chk("rst_occ",       32'(occ),       32'd0);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        tick();
        rst_n = 1'b1;

        // Fill 3,1,6 with issue enabled throughout: order 3,1,6
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(6);
        req = 8'hFF; sel_ready = 1'b1;
        ins(3); ins(1); ins(6);
        tick();
        sel_ready = 1'b0;
        @(negedge clk);
        chk("fill_empty", 32'(empty), 32'd1);
        chk("fill_occ",   32'(occ),   32'd0);
        tick();

        // Readiness skip: oldest slot 3 not requesting, slot 1 wins
        req = '0;
        ins(3); ins(1); ins(6);
        @(negedge clk);
        chk("skip_occ",   32'(occ),       32'h4A);
        chk("skip_idle",  32'(sel_valid), 32'd0);
        tick();
        exp_q.push_back(1);
        req = 8'b0100_0010; sel_ready = 1'b1;
        tick();
        exp_q.push_back(3); exp_q.push_back(6);
        req = 8'hFF;
        tick(); tick();
        sel_ready = 1'b0;
        @(negedge clk);
        chk("skip_empty", 32'(empty), 32'd1);
        tick();

        // Same-slot reuse: issue 2 while re-inserting 2 -> 5,7,2
        req = '0;
        ins(2); ins(5); ins(7);
        exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(2);
        req = 8'hFF; sel_ready = 1'b1;
        ins(2);
        @(negedge clk);
        chk("reuse_occ", 32'(occ), 32'hA4);
        tick(); tick(); tick();
        sel_ready = 1'b0;
        @(negedge clk);
        chk("reuse_empty", 32'(empty), 32'd1);
        tick();

        // Backpressure: offer holds, nothing leaves
        req = '0;
        ins(4); ins(0);
        req = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(sel_valid), 32'd1);
            chk("bp_idx",   32'(sel_idx),   32'd4);
            chk("bp_occ",   32'(occ),       32'h11);
            tick();
        end
        exp_q.push_back(4); exp_q.push_back(0);
        sel_ready = 1'b1;
        tick(); tick();
        sel_ready = 1'b0;
        @(negedge clk);
        chk("bp_empty", 32'(empty), 32'd1);
        tick();

        // Flush: fill all slots, then flush with a colliding insert and a handshake
        req = '0;
        for (int i = 0; i < 8; i++) ins(i);
        @(negedge clk);
        chk("full_full",  32'(full),  32'd1);
        chk("full_occ",   32'(occ),   32'hFF);
        chk("full_empty", 32'(empty), 32'd0);
        tick();
        exp_q.push_back(0);
        flush = 1'b1; ins_valid = 1'b1; ins_idx = 3'd3; req = 8'hFF; sel_ready = 1'b1;
        tick();
        flush = 1'b0; ins_valid = 1'b0; sel_ready = 1'b0;
        @(negedge clk);
        chk("flush_occ",   32'(occ),       32'd0);
        chk("flush_empty", 32'(empty),     32'd1);
        chk("flush_valid", 32'(sel_valid), 32'd0);
        chk("flush_full",  32'(full),      32'd0);
        tick();

        // Async reset pulse while an issue is offered
        req = '0;
        ins(5); ins(6);
        req = 8'hFF;
        @(negedge clk);
        chk("prerst_valid", 32'(sel_valid), 32'd1);
        chk("prerst_idx",   32'(sel_idx),   32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(sel_valid), 32'd0);
        chk("arst_idx",   32'(sel_idx),   32'd0);
        chk("arst_occ",   32'(occ),       32'd0);
        chk("arst_empty", 32'(empty),     32'd1);
        chk("arst_full",  32'(full),      32'd0);
        tick();
        rst_n = 1'b1;
        req   = '0;
        tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_age_matrix_issue_sel
